// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects, FSM
// states and the shadow-scoreboard entry.
package hazard_pkg;

  localparam int REG_AW = 5;

  typedef enum logic [1:0] {
    FWD_RF    = 2'b00,
    FWD_EXMEM = 2'b01,
    FWD_MEMWB = 2'b10
  } fwd_sel_t;

  typedef enum logic {
    RUN   = 1'b0,
    FLUSH = 1'b1
  } hz_state_t;

  typedef struct packed {
    logic              valid;
    logic [REG_AW-1:0] rd;
    logic              writes;
    logic              load;
  } sb_entry_t;

  // x0 never matches: it reads as zero no matter who claims to write it.
  function automatic logic sb_match(sb_entry_t e, logic [REG_AW-1:0] rs, logic uses);
    return e.valid & e.writes & (e.rd == rs) & (rs != '0) & uses;
  endfunction

endpackage

// File: rtl/hazard_fwd_cmp.sv
// Per-source-operand compare against the EX and MEM scoreboard entries:
// forwarding select (EX wins over MEM) and a load-use hit flag.
module hazard_fwd_cmp
  import hazard_pkg::*;
(
  input  sb_entry_t         ex_i,
  input  sb_entry_t         mem_i,
  input  logic [REG_AW-1:0] rs_i,
  input  logic              uses_i,
  output fwd_sel_t          sel_o,
  output logic              load_hit_o
);

  logic ex_hit, mem_hit;
  logic mem_load_unused;

  assign ex_hit          = sb_match(ex_i, rs_i, uses_i);
  assign mem_hit         = sb_match(mem_i, rs_i, uses_i);
  assign mem_load_unused = mem_i.load;

  always_comb begin
    sel_o = FWD_RF;
    if (ex_hit)       sel_o = FWD_EXMEM;
    else if (mem_hit) sel_o = FWD_MEMWB;
  end

  assign load_hit_o = ex_hit & ex_i.load;

endmodule

// File: rtl/hazard_ctrl.sv
// 5-stage pipeline hazard controller: load-use stall, taken-branch flush and
// EX forwarding selects. Define HAZARD_CTRL_PERF_EN to add stall/flush counters.
module hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int unsigned FLUSH_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs1,
  input  logic [REG_AW-1:0] id_rs2,
  input  logic              id_uses_rs1,
  input  logic              id_uses_rs2,
  input  logic [REG_AW-1:0] id_rd,
  input  logic              id_writes,
  input  logic              id_load,
  input  logic              branch_taken,
  output logic              stall,
  output logic              bubble,
  output logic              flush,
  output logic [1:0]        fwd_a,
`ifdef HAZARD_CTRL_PERF_EN
  output logic [1:0]        fwd_b,
  output logic [31:0]       perf_stall_cnt,
  output logic [31:0]       perf_flush_cnt
`else
  output logic [1:0]        fwd_b
`endif
);

  localparam int CNT_W = 3;

  hz_state_t        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  sb_entry_t        ex_q, mem_q, wb_q, ex_d;
  fwd_sel_t         fwd_a_q, fwd_b_q;

  logic [1:0][REG_AW-1:0] rs;
  logic [1:0]             uses;
  logic [1:0]             ld_hit;
  fwd_sel_t               sel [2];
  logic                   wb_unused;

  assign rs   = {id_rs2, id_rs1};
  assign uses = {id_uses_rs2, id_uses_rs1};

  for (genvar g = 0; g < 2; g++) begin : g_src
    hazard_fwd_cmp u_cmp (
      .ex_i       (ex_q),
      .mem_i      (mem_q),
      .rs_i       (rs[g]),
      .uses_i     (uses[g]),
      .sel_o      (sel[g]),
      .load_hit_o (ld_hit[g])
    );
  end

  // WB is tracked for completeness of the shadow pipe; nothing forwards from it.
  assign wb_unused = ^wb_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    flush   = 1'b0;
    case (state_q)
      RUN: begin
        if (branch_taken) begin
          flush = 1'b1;
          if (FLUSH_CYCLES > 1) begin
            state_d = FLUSH;
            cnt_d   = CNT_W'(FLUSH_CYCLES - 1);
          end
        end
      end
      FLUSH: begin
        flush = 1'b1;
        if (branch_taken) begin
          cnt_d = CNT_W'(FLUSH_CYCLES - 1);
        end else if (cnt_q <= CNT_W'(1)) begin
          state_d = RUN;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = RUN;
    endcase
    stall  = (state_q == RUN) & ~flush & id_valid & (|ld_hit);
    bubble = flush | stall;
  end

  always_comb begin
    ex_d        = '0;
    ex_d.valid  = id_valid & ~bubble;
    ex_d.rd     = id_rd;
    ex_d.writes = id_writes;
    ex_d.load   = id_load;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= RUN;
      cnt_q   <= '0;
      ex_q    <= '0;
      mem_q   <= '0;
      wb_q    <= '0;
      fwd_a_q <= FWD_RF;
      fwd_b_q <= FWD_RF;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      wb_q    <= mem_q;
      mem_q   <= ex_q;
      ex_q    <= ex_d;
      fwd_a_q <= bubble ? FWD_RF : sel[0];
      fwd_b_q <= bubble ? FWD_RF : sel[1];
    end
  end

  assign fwd_a = fwd_a_q;
  assign fwd_b = fwd_b_q;

`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_q, perf_flush_q;

  // Flush counts branch events, so a reload during FLUSH counts again.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_stall_q <= '0;
      perf_flush_q <= '0;
    end else begin
      if (stall && perf_stall_q != '1)        perf_stall_q <= perf_stall_q + 32'd1;
      if (branch_taken && perf_flush_q != '1) perf_flush_q <= perf_flush_q + 32'd1;
    end
  end

  assign perf_stall_cnt = perf_stall_q;
  assign perf_flush_cnt = perf_flush_q;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (FLUSH_CYCLES = 2): forwarding, load-use,
// x0, branch flush/reload, async reset, and perf counters when enabled.
module tb_hazard_ctrl;
  logic       clk = 1'b0;
  logic       reset;
  logic       id_valid, id_uses_rs1, id_uses_rs2, id_writes, id_load, branch_taken;
  logic [4:0] id_rs1, id_rs2, id_rd;
  logic       stall, bubble, flush;
  logic [1:0] fwd_a, fwd_b;
`ifdef HAZARD_CTRL_PERF_EN
  logic [31:0] perf_stall_cnt, perf_flush_cnt;
`endif

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.FLUSH_CYCLES(2)) dut (
    .clk(clk), .reset(reset),
    .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_uses_rs1(id_uses_rs1), .id_uses_rs2(id_uses_rs2),
    .id_rd(id_rd), .id_writes(id_writes), .id_load(id_load),
    .branch_taken(branch_taken),
    .stall(stall), .bubble(bubble), .flush(flush),
    .fwd_a(fwd_a),
`ifdef HAZARD_CTRL_PERF_EN
    .fwd_b(fwd_b),
    .perf_stall_cnt(perf_stall_cnt), .perf_flush_cnt(perf_flush_cnt)
`else
    .fwd_b(fwd_b)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
  endtask

  task automatic drive(input logic v, input logic [4:0] r1, input logic [4:0] r2,
                       input logic u1, input logic u2, input logic [4:0] rd,
                       input logic wr, input logic ld, input logic br);
    id_valid = v; id_rs1 = r1; id_rs2 = r2; id_uses_rs1 = u1; id_uses_rs2 = u2;
    id_rd = rd; id_writes = wr; id_load = ld; branch_taken = br;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_ctl(input string tag, input logic s, input logic b, input logic f);
    chk({tag, ".stall"}, 32'(stall), 32'(s));
    chk({tag, ".bubble"}, 32'(bubble), 32'(b));
    chk({tag, ".flush"}, 32'(flush), 32'(f));
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #2;
    chk_ctl("reset", 0, 0, 0);
    chk("reset.fwd_a", 32'(fwd_a), 32'h0);
    chk("reset.fwd_b", 32'(fwd_b), 32'h0);
    tick(); tick();
    reset = 1'b0;
    idle(2);

    // back-to-back: add x5 ; add x6,x5,x1
    drive(1, 1, 2, 1, 1, 5, 1, 0, 0); tick();
    drive(1, 5, 1, 1, 1, 6, 1, 0, 0); #1;
    chk_ctl("b2b", 0, 0, 0);
    tick();
    chk("b2b.fwd_a", 32'(fwd_a), 32'h1);
    chk("b2b.fwd_b", 32'(fwd_b), 32'h0);
    idle(3);

    // one gap: add x9 ; add x10 ; add rs1=x9 rs2=x10
    drive(1, 1, 2, 1, 1, 9, 1, 0, 0); tick();
    drive(1, 3, 4, 1, 1, 10, 1, 0, 0); tick();
    drive(1, 9, 10, 1, 1, 11, 1, 0, 0); tick();
    chk("gap.fwd_a", 32'(fwd_a), 32'h2);
    chk("gap.fwd_b", 32'(fwd_b), 32'h1);
    idle(3);

    // EX beats MEM when both hold the same rd
    drive(1, 1, 2, 1, 1, 14, 1, 0, 0); tick();
    drive(1, 3, 4, 1, 1, 14, 1, 0, 0); tick();
    drive(1, 14, 0, 1, 0, 15, 1, 0, 0); tick();
    chk("prio.fwd_a", 32'(fwd_a), 32'h1);
    idle(3);

    // load-use: lw x7 ; add x8,x7,x7
    drive(1, 1, 0, 1, 0, 7, 1, 1, 0); tick();
    drive(1, 7, 7, 1, 1, 8, 1, 0, 0); #1;
    chk_ctl("lu.c1", 1, 1, 0);
    tick();
    chk("lu.bub.fwd_a", 32'(fwd_a), 32'h0);
    chk_ctl("lu.c2", 0, 0, 0);
    tick();
    chk("lu.fwd_a", 32'(fwd_a), 32'h2);
    chk("lu.fwd_b", 32'(fwd_b), 32'h2);
    idle(3);

    // lw x0 ; use x0
    drive(1, 1, 0, 1, 0, 0, 1, 1, 0); tick();
    drive(1, 0, 0, 1, 1, 8, 1, 0, 0); #1;
    chk("x0.stall", 32'(stall), 32'h0);
    tick();
    chk("x0.fwd_a", 32'(fwd_a), 32'h0);
    chk("x0.fwd_b", 32'(fwd_b), 32'h0);
    idle(3);

    // register matches but the operand is not read
    drive(1, 1, 0, 1, 0, 11, 1, 1, 0); tick();
    drive(1, 11, 11, 0, 0, 8, 1, 0, 0); #1;
    chk("nouse.stall", 32'(stall), 32'h0);
    idle(3);

    // taken branch with a simultaneous load-use
    drive(1, 1, 0, 1, 0, 12, 1, 1, 0); tick();
    drive(1, 12, 0, 1, 0, 13, 1, 0, 1); #1;
    chk_ctl("br.c0", 0, 1, 1);
    tick();
    drive(1, 12, 0, 1, 0, 13, 1, 0, 0); #1;
    chk_ctl("br.c1", 0, 1, 1);
    tick();
    chk_ctl("br.c2", 0, 0, 0);
    idle(3);

    // branch again during FLUSH reloads the counter
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    #1 chk("rl.c1.flush", 32'(flush), 32'h1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("rl.c2.flush", 32'(flush), 32'h1);
    tick();
    chk("rl.c3.flush", 32'(flush), 32'h0);
    idle(3);

    // async reset mid-FLUSH
    drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0); #1;
    chk("rst.pre.flush", 32'(flush), 32'h1);
    #1 reset = 1'b1;
    #1 chk_ctl("rst.async", 0, 0, 0);
    #1 reset = 1'b0;
    #1 chk_ctl("rst.rel", 0, 0, 0);
    idle(3);

    // reset with a producer in EX drops it
    drive(1, 1, 2, 1, 1, 13, 1, 0, 0); tick();
    drive(1, 13, 0, 1, 0, 16, 1, 0, 0);
    #2 reset = 1'b1;
    #1 reset = 1'b0;
    tick();
    chk("rstsb.fwd_a", 32'(fwd_a), 32'h0);
    idle(3);

    // three load-use stalls, two taken branches
    for (int i = 0; i < 3; i++) begin
      drive(1, 1, 0, 1, 0, 5'(20 + i), 1, 1, 0); tick();
      drive(1, 5'(20 + i), 0, 1, 0, 25, 1, 0, 0); tick(); tick();
      idle(2);
    end
    for (int i = 0; i < 2; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0, 0, 1); tick();
      idle(3);
    end
`ifdef HAZARD_CTRL_PERF_EN
    chk("perf.stall", perf_stall_cnt, 32'd3);
    chk("perf.flush", perf_flush_cnt, 32'd2);
`endif
    chk_ctl("end", 0, 0, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
